display_scan: RTL



---
 rtl/display_scan.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/display_scan.sv
// display_scan
//   Multiplexes the BCD time (hh:mm:ss) onto a 6-digit common-anode
//   seven-segment display, one digit per SCAN_DIV clocks. A coherent copy
//   of the time is latched once per frame so a rolling value never tears
//   across digits. In set mode the field being adjusted blinks with a
//   half-period of BLINK_FRAMES frames.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high reset
//   mode         1 = timer mode (separator dots lit), 0 = set mode
//   minute_set   minute field is being adjusted (set mode only)
//   hour_set     hour field is being adjusted (set mode only)
//   second_data  BCD seconds, [7:4] tens, [3:0] ones
//   minute_data  BCD minutes, same layout
//   hour_data    BCD hours, same layout
//   seg          segments, active-low, [0]=a .. [6]=g, [7]=dp
//   digit_sel    digit enables, active-low one-hot
module display_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       minute_set,
  input  logic       hour_set,
  input  logic [7:0] second_data,
  input  logic [7:0] minute_data,
  input  logic [7:0] hour_data,
  output logic [7:0] seg,
  output logic [5:0] digit_sel
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [SW-1:0] scan_cnt;
  logic [2:0]    idx;
  logic [23:0]   snapshot;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  logic          digit_end;
  logic          frame_end;
  logic [3:0]    cur_nibble;
  logic          dp_on;
  logic          blank;
  logic [7:0]    seg_p0;
  logic [5:0]    sel_p0;

  // BCD digit to active-low segment pattern; dp bit left dark.
  // Non-decimal nibbles show a lone dash.
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hBF;
    endcase
    return s;
  endfunction

  assign digit_end = (scan_cnt == SCAN_LAST);
  assign frame_end = digit_end && (idx == 3'd5);

  // Scan timing: dwell counter and digit index
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= 3'd0;
    end else if (digit_end) begin
      scan_cnt <= '0;
      idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Time snapshot, refreshed only at the frame boundary
  always_ff @(posedge clock) begin
    if (reset) begin
      snapshot <= 24'h0;
    end else if (frame_end) begin
      snapshot <= {hour_data, minute_data, second_data};
    end
  end

  // Blink timing; held at rest in timer mode so set mode always starts
  // with a full visible half-period.
  always_ff @(posedge clock) begin
    if (reset || mode) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Stage p0: select digit, decode, apply separator dots and blanking
  always_comb begin
    cur_nibble = 4'h0;
    case (idx)
      3'd0:    cur_nibble = snapshot[3:0];
      3'd1:    cur_nibble = snapshot[7:4];
      3'd2:    cur_nibble = snapshot[11:8];
      3'd3:    cur_nibble = snapshot[15:12];
      3'd4:    cur_nibble = snapshot[19:16];
      3'd5:    cur_nibble = snapshot[23:20];
      default: cur_nibble = 4'h0;
    endcase

    dp_on = mode && ((idx == 3'd2) || (idx == 3'd4));
    blank = !mode && blink_phase &&
            ((minute_set && ((idx == 3'd2) || (idx == 3'd3))) ||
             (hour_set   && ((idx == 3'd4) || (idx == 3'd5))));

    seg_p0 = seg_decode(cur_nibble);
    if (dp_on) seg_p0[7] = 1'b0;
    if (blank) seg_p0 = 8'hFF;

    sel_p0 = ~(6'b000001 << idx);
  end

  // Stage p1: registered display drive
  always_ff @(posedge clock) begin
    if (reset) begin
      seg       <= 8'hFF;
      digit_sel <= 6'b111111;
    end else begin
      seg       <= seg_p0;
      digit_sel <= sel_p0;
    end
  end

endmodule
